// File: rtl/velocity_cell_reader_if.sv
// ---------------------------------------------------------------------------
// velocity_cell_reader_if
//   Bundles the three channels of the per-cell velocity reader:
//     - RAM port      : mem_addr / mem_rden / mem_wren / mem_data -> RAM,
//                       mem_q <- RAM (valid the cycle after the read)
//     - particle out  : out_valid / out_data / out_pid / out_last -> pipeline,
//                       out_ready <- pipeline
//     - write-back in : wb_valid / wb_pid / wb_data -> reader,
//                       wb_ready <- reader
//   modport master : the reader itself
//   modport slave  : the environment (RAM, velocity cache, motion update)
// ---------------------------------------------------------------------------
interface velocity_cell_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  // RAM port
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_q;

  // particle stream
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_pid;
  logic                  out_last;

  // write-back channel
  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_pid;
  logic [DATA_WIDTH-1:0] wb_data;

  modport master (
    output mem_addr, mem_rden, mem_wren, mem_data,
    input  mem_q,
    output out_valid, out_data, out_pid, out_last,
    input  out_ready,
    input  wb_valid, wb_pid, wb_data,
    output wb_ready
  );

  modport slave (
    input  mem_addr, mem_rden, mem_wren, mem_data,
    output mem_q,
    input  out_valid, out_data, out_pid, out_last,
    output out_ready,
    output wb_valid, wb_pid, wb_data,
    input  wb_ready
  );
endinterface

// File: rtl/velocity_cell_reader.sv
// ---------------------------------------------------------------------------
// velocity_cell_reader
//   Streams the velocities of one cell out of its single-port velocity RAM.
//   Address 0 of the RAM holds the particle count, addresses 1..count hold
//   {vz, vy, vx}. On start the count is read (and clamped to PARTICLE_NUM-1),
//   then particles 1..count are read and presented on a valid/ready stream.
//   A 2-entry skid buffer absorbs the RAM's one-cycle read latency so the
//   stream runs at one particle per cycle and survives back-pressure without
//   dropping or duplicating words. While idle, write-back requests are
//   written straight into the RAM with zero-latency accept.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   start      : begin streaming the cell (only looked at while idle)
//   busy       : high from the cycle after an accepted start until DONE exits
//   done       : one-cycle pulse after the final particle handshake
//   cell_count : latched, clamped particle count
//   bus        : RAM port, particle stream and write-back channel
// ---------------------------------------------------------------------------
module velocity_cell_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] cell_count,
  velocity_cell_reader_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] COUNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_CNT   = 3'd1,
    S_WAIT_CNT = 3'd2,
    S_STREAM   = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Latched particle count and next particle address to read. The read
  // address carries one extra bit so that count+1 never wraps.
  logic [ADDR_WIDTH-1:0] count_reg;
  logic [ADDR_WIDTH:0]   rd_addr_reg;

  // One read may be outstanding in the RAM; its pid travels alongside.
  logic                  inflight_reg;
  logic [ADDR_WIDTH-1:0] inflight_pid_reg;

  // Skid buffer bookkeeping.
  logic                  head_reg;
  logic                  tail_reg;
  logic [1:0]            occ_reg;
  logic [DATA_WIDTH-1:0] entry_data [2];
  logic [ADDR_WIDTH-1:0] entry_pid  [2];

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  last_pop;
  logic                  wb_accept;
  logic [2:0]            pending;
  logic [ADDR_WIDTH-1:0] count_raw;
  logic [ADDR_WIDTH-1:0] count_clamped;

  // -------------------------------------------------------------------------
  // Handshake / issue decisions
  // -------------------------------------------------------------------------
  assign pop      = bus.out_valid && bus.out_ready;
  assign push     = inflight_reg;
  assign last_pop = pop && bus.out_last;

  // Words that will occupy the buffer next cycle before any new read lands:
  // current entries plus the word arriving from the RAM minus the one leaving.
  // A read may only be launched if its word is guaranteed a free slot.
  assign pending = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};

  assign issue = (state_reg == S_STREAM) &&
                 (rd_addr_reg <= {1'b0, count_reg}) &&
                 (pending < 3'd2);

  // The count word is clamped so a corrupted count can never walk past the
  // end of the RAM.
  assign count_raw     = bus.mem_q[ADDR_WIDTH-1:0];
  assign count_clamped = (count_raw > COUNT_MAX) ? COUNT_MAX : count_raw;

  // Start has priority over write-back; rst_n is folded in so no write can
  // slip into the RAM while the block is held in reset.
  assign wb_accept = rst_n && (state_reg == S_IDLE) && !start && bus.wb_valid;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_RD_CNT;
        end
      end
      S_RD_CNT: begin
        state_next = S_WAIT_CNT;
      end
      S_WAIT_CNT: begin
        if (count_clamped == '0) begin
          state_next = S_DONE;
        end else begin
          state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (last_pop) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output logic (RAM port and write-back accept)
  // -------------------------------------------------------------------------
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_rden = 1'b0;
    bus.mem_wren = 1'b0;
    bus.wb_ready = 1'b0;
    case (state_reg)
      S_IDLE: begin
        bus.wb_ready = rst_n && !start;
        if (wb_accept) begin
          bus.mem_wren = 1'b1;
          bus.mem_addr = bus.wb_pid;
        end
      end
      S_RD_CNT: begin
        bus.mem_rden = 1'b1;
      end
      S_STREAM: begin
        if (issue) begin
          bus.mem_rden = 1'b1;
          bus.mem_addr = rd_addr_reg[ADDR_WIDTH-1:0];
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.mem_data = bus.wb_data;
  assign busy         = (state_reg != S_IDLE);
  assign done         = (state_reg == S_DONE);
  assign cell_count   = count_reg;

  // -------------------------------------------------------------------------
  // Count latch, read address and in-flight tracking
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg        <= '0;
      rd_addr_reg      <= '0;
      inflight_reg     <= 1'b0;
      inflight_pid_reg <= '0;
    end else begin
      if (state_reg == S_WAIT_CNT) begin
        count_reg   <= count_clamped;
        rd_addr_reg <= (ADDR_WIDTH+1)'(1);
      end else if (issue) begin
        rd_addr_reg <= rd_addr_reg + 1'b1;
      end
      inflight_reg <= issue;
      if (issue) begin
        inflight_pid_reg <= rd_addr_reg[ADDR_WIDTH-1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Skid buffer: two entries written at tail, read from head
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] data_reg;
      logic [ADDR_WIDTH-1:0] pid_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
          pid_reg  <= '0;
        end else if (push && (tail_reg == 1'(gi))) begin
          data_reg <= bus.mem_q;
          pid_reg  <= inflight_pid_reg;
        end
      end

      assign entry_data[gi] = data_reg;
      assign entry_pid[gi]  = pid_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg <= 1'b0;
      tail_reg <= 1'b0;
      occ_reg  <= '0;
    end else begin
      if (push) begin
        tail_reg <= ~tail_reg;
      end
      if (pop) begin
        head_reg <= ~head_reg;
      end
      occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.out_valid = (occ_reg != 2'd0);
  assign bus.out_data  = entry_data[head_reg];
  assign bus.out_pid   = entry_pid[head_reg];
  assign bus.out_last  = bus.out_valid && (entry_pid[head_reg] == count_reg);

endmodule

// File: tb/tb_velocity_cell_reader.sv
// ---------------------------------------------------------------------------
// tb_velocity_cell_reader
//   Drives velocity_cell_reader against a behavioural RAM. The reference is a
//   shadow copy of what the RAM should contain (model_mem): the expected
//   stream for a start is simply model_mem[1..min(count, PARTICLE_NUM-1)]
//   in order, with timing taken from the cycle numbers of the block's
//   contract.
// ---------------------------------------------------------------------------
module tb_velocity_cell_reader;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] cell_count;

  velocity_cell_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  velocity_cell_reader #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .PARTICLE_NUM(PN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .cell_count(cell_count),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with a registered read, plus a bench-side
  // preload port used only while the reader is idle.
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_q;
  logic          pl_we   = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_data;
    if (bus.mem_rden) ram_q <= ram[bus.mem_addr];
  end
  assign bus.mem_q = ram_q;

  // Reference contents of the RAM.
  logic [DW-1:0] model_mem [256];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_count();
    int c;
    c = int'(model_mem[0][AW-1:0]);
    return (c > PN - 1) ? PN - 1 : c;
  endfunction

  function automatic logic pick_ready(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return c[0];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic preload_word(input int a, input logic [DW-1:0] d);
    pl_addr = AW'(a);
    pl_data = d;
    pl_we   = 1'b1;
    model_mem[a] = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  task automatic set_count(input int n);
    logic [DW-1:0] w;
    w = {$urandom, $urandom, 24'($urandom), 8'(n)};
    preload_word(0, w);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_done"},  done, 1'b0);
    check({tag, "_valid"}, bus.out_valid, 1'b0);
    check({tag, "_rden"},  bus.mem_rden, 1'b0);
    check({tag, "_wren"},  bus.mem_wren, 1'b0);
    check({tag, "_addr"},  bus.mem_addr, '0);
    check({tag, "_count"}, cell_count, '0);
    check({tag, "_data"},  bus.out_data, '0);
    check({tag, "_pid"},   bus.out_pid, '0);
  endtask

  // Runs one start..done sequence. mode: 0 ready held high, 1 toggling,
  // 2 random. abort_pid > 0 returns right after that pid's handshake is seen.
  // wb_with_start raises wb_valid in the same cycle as start.
  task automatic run_cell(input int mode, input int abort_pid, input bit wb_with_start);
    int  n, exp_pid, issued, popped, last_hs, budget;
    bit  hs, got_done, prev_stall, exp_rden;
    logic [AW-1:0] prev_pid;
    logic [DW-1:0] prev_data;

    n = exp_count();
    exp_pid = 1; issued = 0; popped = 0; last_hs = 0;
    got_done = 1'b0; prev_stall = 1'b0;
    prev_pid = '0; prev_data = '0;
    budget = 100 + 8 * n;

    @(negedge clk);
    start = 1'b1;
    if (wb_with_start) bus.wb_valid = 1'b1;
    #1;
    check("start_blocks_wb_ready", bus.wb_ready, 1'b0);
    check("start_blocks_wren", bus.mem_wren, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    bus.out_ready = pick_ready(mode, 1);

    for (int c = 1; c <= budget && !got_done; c++) begin
      @(negedge clk);
      hs = bus.out_valid && bus.out_ready;
      check("busy", busy, 1'b1);
      check("wb_ready_busy", bus.wb_ready, 1'b0);
      check("wren_busy", bus.mem_wren, 1'b0);
      if (c < 5 || n == 0) check("early_valid", bus.out_valid, 1'b0);
      if (c == 5 && n > 0) check("first_valid", bus.out_valid, 1'b1);
      if (c >= 3) check("cell_count", cell_count, n);
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1'b1);
        check("stall_pid", bus.out_pid, prev_pid);
        check("stall_data", bus.out_data, prev_data);
      end
      if (c == 1) begin
        check("cnt_rden", bus.mem_rden, 1'b1);
        check("cnt_addr", bus.mem_addr, '0);
      end else if (c == 2 || done) begin
        check("idle_rden", bus.mem_rden, 1'b0);
      end else begin
        exp_rden = (issued < n) && (issued - popped - int'(hs) < 2);
        check("rd_issue", bus.mem_rden, exp_rden);
        if (bus.mem_rden) begin
          check("rd_addr", bus.mem_addr, issued + 1);
          issued++;
        end
        check("buffered_le2", (issued - popped - int'(hs)) <= 2, 1'b1);
      end
      if (hs) begin
        check("pid", bus.out_pid, exp_pid);
        check("data", bus.out_data, model_mem[exp_pid]);
        check("last", bus.out_last, exp_pid == n);
        $display("beat pid=%0d data=%h last=%0b cycle=%0d", bus.out_pid, bus.out_data, bus.out_last, c);
        popped++;
        last_hs = c;
        if (exp_pid == abort_pid) return;
        exp_pid++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_pid   = bus.out_pid;
      prev_data  = bus.out_data;
      if (done) begin
        got_done = 1'b1;
        if (n == 0) check("done_cycle", c, 3);
        else check("done_cycle", c, last_hs + 1);
        if (mode == 0 && n > 0) check("done_cycle_full_rate", c, 5 + n);
        check("all_delivered", exp_pid, n + 1);
        $display("cell count=%0d mode=%0d done at cycle %0d", n, mode, c);
      end else begin
        @(posedge clk);
        #1 bus.out_ready = pick_ready(mode, c + 1);
      end
    end
    check("done_seen", got_done, 1'b1);

    @(posedge clk);
    @(negedge clk);
    check("busy_after", busy, 1'b0);
    check("done_after", done, 1'b0);
    check("wb_ready_after", bus.wb_ready, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] wd;
    int            wp;

    bus.out_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_pid    = '0;
    bus.wb_data   = '0;

    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");

    for (int a = 1; a < PN; a++) preload_word(a, {$urandom, $urandom, $urandom});
    @(negedge clk) rst_n = 1'b1;

    // Count 4 at full rate.
    set_count(4);
    run_cell(0, 0, 1'b0);

    // Empty cell.
    set_count(0);
    run_cell(0, 0, 1'b0);

    // Count 10 with toggling and random back-pressure.
    set_count(10);
    run_cell(1, 0, 1'b0);
    run_cell(2, 0, 1'b0);

    // Oversized count gets clamped.
    set_count(250);
    run_cell(2, 0, 1'b0);
    check("clamped_count", cell_count, PN - 1);

    // Back-to-back write-backs while idle, including a count rewrite.
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      #1;
      wp = (k == 6) ? 0 : int'($urandom_range(1, 15));
      wd = (k == 6) ? {$urandom, $urandom, 24'($urandom), 8'd12} : {$urandom, $urandom, $urandom};
      bus.wb_valid = 1'b1;
      bus.wb_pid   = AW'(wp);
      bus.wb_data  = wd;
      @(negedge clk);
      check("wb_ready_idle", bus.wb_ready, 1'b1);
      check("wb_wren", bus.mem_wren, 1'b1);
      check("wb_addr", bus.mem_addr, wp);
      check("wb_data", bus.mem_data, wd);
      $display("writeback pid=%0d data=%h", wp, wd);
      model_mem[wp] = wd;
      @(posedge clk);
    end
    #1 bus.wb_valid = 1'b0;
    run_cell(2, 0, 1'b0);

    // Write-back raised together with start: stalls through the stream,
    // lands once idle, and the next stream returns the new pid 3 data.
    set_count(8);
    wd = {$urandom, $urandom, $urandom};
    bus.wb_pid  = AW'(3);
    bus.wb_data = wd;
    run_cell(0, 0, 1'b1);
    check("late_wb_wren", bus.mem_wren, 1'b1);
    check("late_wb_addr", bus.mem_addr, 3);
    check("late_wb_data", bus.mem_data, wd);
    model_mem[3] = wd;
    @(posedge clk);
    #1 bus.wb_valid = 1'b0;
    @(negedge clk);
    check("single_write", bus.mem_wren, 1'b0);
    run_cell(0, 0, 1'b0);

    // Reset in the middle of a 20-particle stream, then a clean restart.
    set_count(20);
    run_cell(0, 5, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    check_reset_outputs("heldreset");
    @(negedge clk) rst_n = 1'b1;
    run_cell(0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
